// File: rtl/fractal_pkg.sv
// Shared types and defaults for the fractal pixel scheduler.
// Optional PERF_CNT_EN build adds per-frame cycle/stall counters.
package fractal_pkg;

    localparam int NUM_ENG_DEF = 4;
    localparam int X_SIZE_DEF  = 640;
    localparam int Y_SIZE_DEF  = 480;
    localparam int CW_DEF      = 16;
    localparam int ITW_DEF     = 8;

    localparam logic MODE_MANDEL = 1'b0;
    localparam logic MODE_JULIA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/fractal_raster_counter.sv
// Raster (x,y) job counter with wrap and first/eol/last flags.
// Advances one pixel per dispatch; wraps to (0,0) after the frame.
module fractal_raster_counter
    import fractal_pkg::*;
#(
    parameter int CW     = CW_DEF,
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          advance_i,
    output logic [CW-1:0] x_o,
    output logic [CW-1:0] y_o,
    output logic          first_o,
    output logic          eol_o,
    output logic          last_o
);

    localparam logic [CW-1:0] XMAX = CW'(X_SIZE - 1);
    localparam logic [CW-1:0] YMAX = CW'(Y_SIZE - 1);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    assign eol_o   = (x_q == XMAX);
    assign last_o  = eol_o && (y_q == YMAX);
    assign first_o = (x_q == '0) && (y_q == '0);
    assign x_o     = x_q;
    assign y_o     = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance_i) begin
            if (eol_o) begin
                x_d = '0;
                y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/fractal_pixel_scheduler.sv
// Round-robin job dispatch to NUM_ENG engines, in-order pixel retire.
// Define PERF_CNT_EN to add perf_cycles/perf_stalls outputs.
module fractal_pixel_scheduler
    import fractal_pkg::*;
#(
    parameter int NUM_ENG = NUM_ENG_DEF,
    parameter int X_SIZE  = X_SIZE_DEF,
    parameter int Y_SIZE  = Y_SIZE_DEF,
    parameter int CW      = CW_DEF,
    parameter int ITW     = ITW_DEF
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   cfg_enable,
    input  logic                   cfg_mode,
    input  logic [ITW-1:0]         cfg_max_iter,
    output logic [NUM_ENG-1:0]     eng_start,
    output logic [CW-1:0]          eng_x,
    output logic [CW-1:0]          eng_y,
    output logic                   eng_mode,
    output logic [ITW-1:0]         eng_max_iter,
    input  logic [NUM_ENG-1:0]     eng_done,
    input  logic [NUM_ENG*ITW-1:0] eng_iter,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [ITW-1:0]         pix_iter,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   frame_done
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]            perf_cycles,
    output logic [31:0]            perf_stalls
`endif
);

    localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    state_e         state_q, state_d;
    logic           latch_cfg;
    logic [PW-1:0]  disp_ptr_q, ret_ptr_q;
    logic [NUM_ENG-1:0] busy_q, res_vld_q;
    logic [NUM_ENG-1:0] res_sof_q, res_eol_q, res_last_q;
    logic [ITW-1:0] res_iter_q [NUM_ENG];
    logic           pix_valid_q, pix_sof_q, pix_eol_q, pix_last_q;
    logic [ITW-1:0] pix_iter_q;
    logic           mode_q;
    logic [ITW-1:0] max_iter_q;
    logic           rc_first, rc_eol, rc_last;
    logic           dispatch, retire, accept;

    fractal_raster_counter #(
        .CW     (CW),
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_raster (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .advance_i (dispatch),
        .x_o       (eng_x),
        .y_o       (eng_y),
        .first_o   (rc_first),
        .eol_o     (rc_eol),
        .last_o    (rc_last)
    );

    // A slot stays reserved until its result has left for the packer.
    assign dispatch = (state_q == RUN) &&
                      !busy_q[disp_ptr_q] && !res_vld_q[disp_ptr_q];
    assign accept   = pix_valid_q && pix_ready;
    assign retire   = res_vld_q[ret_ptr_q] && (!pix_valid_q || pix_ready);

    assign frame_done   = accept && pix_last_q;
    assign pix_valid    = pix_valid_q;
    assign pix_iter     = pix_iter_q;
    assign pix_sof      = pix_sof_q;
    assign pix_eol      = pix_eol_q;
    assign eng_mode     = mode_q;
    assign eng_max_iter = max_iter_q;

    always_comb begin
        eng_start = '0;
        eng_start[disp_ptr_q] = dispatch;
    end

    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_enable) begin
                    state_d   = RUN;
                    latch_cfg = 1'b1;
                end
            end
            RUN: begin
                if (dispatch && rc_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (frame_done) begin
                    state_d   = cfg_enable ? RUN : IDLE;
                    latch_cfg = cfg_enable;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            max_iter_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_cfg) begin
                mode_q     <= cfg_mode;
                max_iter_q <= cfg_max_iter;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            disp_ptr_q <= '0;
            ret_ptr_q  <= '0;
            busy_q     <= '0;
            res_vld_q  <= '0;
            res_sof_q  <= '0;
            res_eol_q  <= '0;
            res_last_q <= '0;
            for (int i = 0; i < NUM_ENG; i++) res_iter_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_done[i] && busy_q[i]) begin
                    busy_q[i]     <= 1'b0;
                    res_vld_q[i]  <= 1'b1;
                    res_iter_q[i] <= eng_iter[i*ITW +: ITW];
                end
            end
            if (dispatch) begin
                busy_q[disp_ptr_q]     <= 1'b1;
                res_sof_q[disp_ptr_q]  <= rc_first;
                res_eol_q[disp_ptr_q]  <= rc_eol;
                res_last_q[disp_ptr_q] <= rc_last;
                disp_ptr_q             <= disp_ptr_q + 1'b1;
            end
            if (retire) begin
                res_vld_q[ret_ptr_q] <= 1'b0;
                ret_ptr_q            <= ret_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pix_valid_q <= 1'b0;
            pix_iter_q  <= '0;
            pix_sof_q   <= 1'b0;
            pix_eol_q   <= 1'b0;
            pix_last_q  <= 1'b0;
        end else if (retire) begin
            pix_valid_q <= 1'b1;
            pix_iter_q  <= res_iter_q[ret_ptr_q];
            pix_sof_q   <= res_sof_q[ret_ptr_q];
            pix_eol_q   <= res_eol_q[ret_ptr_q];
            pix_last_q  <= res_last_q[ret_ptr_q];
        end else if (accept) begin
            pix_valid_q <= 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt_q, stall_cnt_q, perf_cycles_q, perf_stalls_q;
    logic        cnt_act_q;

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;

    // Window opens on the (0,0) dispatch and closes on frame_done.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_act_q     <= 1'b0;
            cyc_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else if (frame_done) begin
            cnt_act_q     <= 1'b0;
            stall_cnt_q   <= '0;
            perf_cycles_q <= cyc_cnt_q + 32'd1;
            perf_stalls_q <= stall_cnt_q;
        end else begin
            if (dispatch && rc_first) begin
                cnt_act_q <= 1'b1;
                cyc_cnt_q <= 32'd1;
            end else if (cnt_act_q) begin
                cyc_cnt_q <= cyc_cnt_q + 32'd1;
            end
            if (pix_valid_q && !pix_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule
